gin_spike_accumulator: RTL and testbench

GIN_SPIKE_ACCUMULATOR -- requirements
Module: gin_spike_accumulator

---
 rtl/gin_spike_accumulator_pkg.sv | 14 +
 rtl/gin_spike_accumulator_if.sv | 31 +++
 rtl/gin_sat_adder.sv | 24 ++
 rtl/gin_spike_accumulator.sv | 69 ++++++
 tb/tb_gin_spike_accumulator.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gin_spike_accumulator_pkg.sv
// Shared Q-format constants and FSM encoding for the conductance datapath.
// The leak unit and the spike accumulator both import this package.
package gin_spike_accumulator_pkg;
  localparam int GIN_INTEGER_WIDTH = 32;
  localparam int GIN_FRAC_WIDTH    = 32;
  localparam int GIN_DATA_WIDTH    = GIN_INTEGER_WIDTH + GIN_FRAC_WIDTH;
  localparam int GIN_COUNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } gin_state_t;
endpackage

// File: rtl/gin_spike_accumulator_if.sv
// Timestep control, weight stream and result handshake of the spike accumulator.
interface gin_spike_accumulator_if
  import gin_spike_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH  = GIN_DATA_WIDTH,
  parameter int COUNT_WIDTH = GIN_COUNT_WIDTH
);
  logic                          Start;
  logic signed [DATA_WIDTH-1:0]  ginIn;
  logic                          WeightValid;
  logic                          WeightReady;
  logic signed [DATA_WIDTH-1:0]  Weight;
  logic                          WeightLast;
  logic                          Finish;
  logic signed [DATA_WIDTH-1:0]  ginOut;
  logic                          OutValid;
  logic                          OutReady;
  logic        [COUNT_WIDTH-1:0] EventCount;
  logic                          Saturated;
  logic                          Busy;

  modport master (
    output Start, ginIn, WeightValid, Weight, WeightLast, Finish, OutReady,
    input  WeightReady, ginOut, OutValid, EventCount, Saturated, Busy
  );

  modport slave (
    input  Start, ginIn, WeightValid, Weight, WeightLast, Finish, OutReady,
    output WeightReady, ginOut, OutValid, EventCount, Saturated, Busy
  );
endinterface

// File: rtl/gin_sat_adder.sv
// Combinational signed add with one guard bit, clipped to the word range.
module gin_sat_adder
  import gin_spike_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = GIN_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] sum,
  output logic                         ovf
);
  logic signed [DATA_WIDTH:0] wide;

  // Guard bit disagreeing with the word MSB means the true sum left the range.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH:0] x);
    if (x[DATA_WIDTH] != x[DATA_WIDTH-1])
      return x[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return x[DATA_WIDTH-1:0];
  endfunction

  assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
  assign ovf  = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
  assign sum  = saturate(wide);
endmodule

// File: rtl/gin_spike_accumulator.sv
// Accumulates synaptic weights onto the leaked conductance over one timestep
// and presents the clipped result through a valid/ready handshake.
module gin_spike_accumulator
  import gin_spike_accumulator_pkg::*;
#(
  parameter int INTEGER_WIDTH   = GIN_INTEGER_WIDTH,
  parameter int DATA_WIDTH_FRAC = GIN_FRAC_WIDTH,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int COUNT_WIDTH     = GIN_COUNT_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  gin_spike_accumulator_if.slave   bus
);
  gin_state_t                    state, state_next;
  logic signed [DATA_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0]  sum;
  logic                          ovf;
  logic        [COUNT_WIDTH-1:0] count;
  logic                          sat;
  logic                          accept;

  gin_sat_adder #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a   (acc),
    .b   (bus.Weight),
    .sum (sum),
    .ovf (ovf)
  );

  assign accept = bus.WeightValid && (state == ACCUM);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = ACCUM;
      // A closing weight is still absorbed on the same edge that leaves ACCUM.
      ACCUM:   if ((accept && bus.WeightLast) || bus.Finish) state_next = OUTPUT;
      OUTPUT:  if (bus.OutReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.Start) begin
        acc   <= bus.ginIn;
        count <= '0;
        sat   <= 1'b0;
      end else if (accept) begin
        acc   <= sum;
        count <= (&count) ? count : count + 1'b1;
        sat   <= sat | ovf;
      end
    end
  end

  assign bus.WeightReady = (state == ACCUM);
  assign bus.OutValid    = (state == OUTPUT);
  assign bus.ginOut      = acc;
  assign bus.EventCount  = count;
  assign bus.Saturated   = sat;
  assign bus.Busy        = (state != IDLE);
endmodule

// File: tb/tb_gin_spike_accumulator.sv
// Randomized and directed timesteps checked against an arithmetic model of
// saturating conductance accumulation.
module tb_gin_spike_accumulator;
  localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

  logic Clock;
  logic Reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  gin_spike_accumulator_if bus ();

  gin_spike_accumulator dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  // Reference: the sum of two Q32.32 numbers, pinned to the representable range.
  task automatic model_add(inout longint acc, input longint w, inout bit clipped);
    longint max_v, min_v;
    max_v = 64'sh7FFF_FFFF_FFFF_FFFF;
    min_v = 64'sh8000_0000_0000_0000;
    if (w > 0 && acc > max_v - w) begin acc = max_v; clipped = 1; end
    else if (w < 0 && acc < min_v - w) begin acc = min_v; clipped = 1; end
    else acc = acc + w;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // mode 0: Last on final weight, 1: separate Finish cycle, 2: Last and Finish together
  task automatic run_ts(input logic [63:0] g, input logic [63:0] w[$], input int mode,
                        input bit gaps, input int bp);
    longint e;
    bit     es;
    int     n;
    bit     last;
    e = g; es = 0; n = 0;
    bus.Start = 1; bus.ginIn = g;
    step();
    bus.Start = 0; bus.ginIn = rnd64();
    check("ready_in_accum", bus.WeightReady, 1);
    check("busy_in_accum", bus.Busy, 1);
    foreach (w[i]) begin
      if (gaps && i > 0) begin
        bus.WeightValid = 0; bus.WeightLast = $urandom_range(1); bus.Weight = rnd64();
        step();
      end
      last = (i == w.size() - 1);
      bus.WeightValid = 1; bus.Weight = w[i];
      bus.WeightLast = last && (mode != 1);
      bus.Finish = last && (mode == 2);
      model_add(e, longint'(w[i]), es);
      n++;
      step();
    end
    bus.WeightValid = 0; bus.WeightLast = 0; bus.Finish = 0;
    if (mode == 1) begin
      bus.Finish = 1;
      step();
      bus.Finish = 0;
    end
    check("outvalid_latency", bus.OutValid, 1);
    check("ginout", bus.ginOut, e);
    check("event_count", bus.EventCount, 64'(n));
    check("saturated", bus.Saturated, 64'(es));
    check("ready_in_output", bus.WeightReady, 0);
    for (int k = 0; k < bp; k++) begin
      bus.OutReady = 0;
      bus.Start = (k == 1); bus.ginIn = rnd64();
      bus.WeightValid = $urandom_range(1); bus.Weight = rnd64(); bus.Finish = $urandom_range(1);
      step();
      bus.Start = 0; bus.WeightValid = 0; bus.Finish = 0;
      check("hold_valid", bus.OutValid, 1);
      check("hold_ginout", bus.ginOut, e);
      check("hold_count", bus.EventCount, 64'(n));
      check("hold_ready", bus.WeightReady, 0);
    end
    bus.OutReady = 1;
    step();
    bus.OutReady = 0;
    check("idle_valid", bus.OutValid, 0);
    check("idle_busy", bus.Busy, 0);
    check("idle_count_hold", bus.EventCount, 64'(n));
    check("idle_sat_hold", bus.Saturated, 64'(es));
  endtask

  initial begin
    logic [63:0] q[$];
    int nw, mode;

    Reset = 0;
    bus.Start = 0; bus.ginIn = '0; bus.WeightValid = 0; bus.Weight = '0;
    bus.WeightLast = 0; bus.Finish = 0; bus.OutReady = 0;
    repeat (3) step();
    check("rst_outvalid", bus.OutValid, 0);
    check("rst_ginout", bus.ginOut, 0);
    check("rst_ready", bus.WeightReady, 0);
    check("rst_count", bus.EventCount, 0);
    check("rst_sat", bus.Saturated, 0);
    check("rst_busy", bus.Busy, 0);
    Reset = 1;

    bus.Finish = 1; bus.WeightValid = 1; bus.WeightLast = 1;
    step();
    bus.Finish = 0; bus.WeightValid = 0; bus.WeightLast = 0;
    check("idle_finish_ignored", bus.Busy, 0);

    q = {64'h0000_0000_4000_0000, 64'h0000_0000_8000_0000};
    run_ts(64'h0000_0001_8000_0000, q, 0, 0, 0);
    check("basic_2p25", bus.ginOut, 64'h0000_0002_4000_0000);

    q = {64'h0000_0002_0000_0000};
    run_ts(64'h7FFF_FFFF_0000_0000, q, 0, 0, 0);
    check("pos_clip", bus.ginOut, 64'h7FFF_FFFF_FFFF_FFFF);
    q = {64'hFFFF_FFFE_0000_0000};
    run_ts(64'h8000_0001_0000_0000, q, 0, 0, 0);
    check("neg_clip", bus.ginOut, 64'h8000_0000_0000_0000);

    q = {ONE, ONE};
    run_ts(ONE, q, 0, 0, 5);

    q = {};
    run_ts(3 * ONE, q, 1, 0, 0);
    check("finish_only", bus.ginOut, 3 * ONE);
    q = {ONE};
    run_ts(3 * ONE, q, 2, 0, 0);
    check("finish_with_last", bus.ginOut, 4 * ONE);

    q = {ONE, ONE};
    run_ts(0, q, 0, 1, 0);
    check("gaps_count", bus.EventCount, 2);

    // Abandon a timestep in ACCUM, then restart on the first edge out of reset.
    bus.Start = 1; bus.ginIn = 5 * ONE;
    step();
    bus.Start = 0;
    for (int i = 0; i < 3; i++) begin
      bus.WeightValid = 1; bus.Weight = ONE;
      step();
    end
    bus.WeightValid = 0;
    Reset = 0;
    step();
    step();
    check("rstacc_outvalid", bus.OutValid, 0);
    check("rstacc_ginout", bus.ginOut, 0);
    check("rstacc_ready", bus.WeightReady, 0);
    check("rstacc_count", bus.EventCount, 0);
    check("rstacc_sat", bus.Saturated, 0);
    check("rstacc_busy", bus.Busy, 0);
    Reset = 1;
    q = {ONE};
    run_ts(ONE, q, 0, 0, 0);
    check("after_rst_2p0", bus.ginOut, 2 * ONE);

    // Abandon a timestep while its result is waiting in OUTPUT.
    bus.Start = 1; bus.ginIn = ONE;
    step();
    bus.Start = 0; bus.WeightValid = 1; bus.Weight = ONE; bus.WeightLast = 1;
    step();
    bus.WeightValid = 0; bus.WeightLast = 0;
    check("pre_rstout_valid", bus.OutValid, 1);
    Reset = 0;
    step();
    Reset = 1;
    check("rstout_valid", bus.OutValid, 0);
    check("rstout_ginout", bus.ginOut, 0);
    check("rstout_busy", bus.Busy, 0);

    for (int t = 0; t < 40; t++) begin
      q = {};
      nw = $urandom_range(6);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(7) == 0) q.push_back(rnd64());
        else q.push_back(64'(longint'(int'($urandom())) * 16));
      end
      mode = (nw == 0) ? 1 : $urandom_range(2);
      run_ts(($urandom_range(3) == 0) ? rnd64() : 64'(longint'(int'($urandom()))),
             q, mode, 1'($urandom_range(1)), $urandom_range(3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
